// File: rtl/nn_pkg.sv
// Shared types for the MLP inference sequencer: word/vector types, layer select and FSM state.
// Activation behaviour depends on the NN_SEQ_RELU_EN macro (see nn_act).
package nn_pkg;

  localparam int N = 16;
  localparam int W = 16;

  typedef logic [W-1:0] word_t;
  typedef word_t vec_t [N];

  typedef enum logic [2:0] {
    LAYER_IN   = 3'd0,
    LAYER_HID  = 3'd1,
    LAYER_OUT  = 3'd2,
    LAYER_IDLE = 3'd7
  } layer_sel_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_L0,
    S_L1,
    S_L2,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/nn_act.sv
// N-wide combinational hidden-layer activation.
// NN_SEQ_RELU_EN defined: negative words clamp to zero; otherwise words pass through unchanged.
module nn_act
  import nn_pkg::*;
(
  input  vec_t din,
  output vec_t dout
);

  always_comb begin
    for (int i = 0; i < N; i++) begin
`ifdef NN_SEQ_RELU_EN
      dout[i] = din[i][W-1] ? '0 : din[i];
`else
      dout[i] = din[i];
`endif
    end
  end

endmodule

// File: rtl/nn_sequencer.sv
// Steps one sample through the shared mat_mul datapath (layers 0,1,2) and returns mat_out[0] of layer 2.
// Hidden captures go through nn_act, whose behaviour is selected by NN_SEQ_RELU_EN.
module nn_sequencer
  import nn_pkg::*;
#(
  parameter int MM_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  word_t      in_data,
  output layer_sel_t layer,
  output vec_t       l1val,
  output vec_t       l2val,
  output word_t      x_in,
  input  vec_t       mat_out,
  output logic       out_valid,
  input  logic       out_ready,
  output word_t      out_data,
  output logic       busy
);

  localparam int CW = $clog2(MM_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MM_WAIT - 1);

  seq_state_t    state;
  logic [CW-1:0] cnt;
  logic          cap;
  vec_t          act_out;

  nn_act u_act (
    .din  (mat_out),
    .dout (act_out)
  );

  // Each layer stays on the datapath for MM_WAIT cycles to cover its multicycle path.
  assign cap  = (cnt == CNT_LAST);
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      layer     <= LAYER_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      x_in      <= '0;
      out_data  <= '0;
      l1val     <= '{default: '0};
      l2val     <= '{default: '0};
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            x_in     <= in_data;
            cnt      <= '0;
            in_ready <= 1'b0;
            layer    <= LAYER_IN;
            state    <= S_L0;
          end
        end
        S_L0: begin
          if (cap) begin
            l1val <= act_out;
            cnt   <= '0;
            layer <= LAYER_HID;
            state <= S_L1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_L1: begin
          if (cap) begin
            l2val <= act_out;
            cnt   <= '0;
            layer <= LAYER_OUT;
            state <= S_L2;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // The scalar output is taken raw: the output layer is never activated.
        S_L2: begin
          if (cap) begin
            out_data  <= mat_out[0];
            out_valid <= 1'b1;
            cnt       <= '0;
            layer     <= LAYER_IDLE;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          cnt       <= '0;
          layer     <= LAYER_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_sequencer.sv
// Self-checking bench for nn_sequencer with a behavioural 1->16->16->1 datapath stub.
// Expected hidden/output values follow NN_SEQ_RELU_EN when it is defined.
module tb_nn_sequencer;
  import nn_pkg::*;

  localparam int MM_WAIT  = 1;
  localparam int MM_WAIT3 = 3;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  word_t      in_data, x_in, out_data;
  logic [2:0] layer;
  vec_t       l1val, l2val, mat_out;

  logic       i3_valid, i3_ready, o3_valid, o3_ready, busy3;
  word_t      i3_data, x3_in, o3_data;
  logic [2:0] layer3;
  vec_t       l1val3, l2val3, mat3;

  int n_checks = 0;
  int n_fail   = 0;

  nn_sequencer #(.MM_WAIT(MM_WAIT)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .layer(layer), .l1val(l1val), .l2val(l2val), .x_in(x_in), .mat_out(mat_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  nn_sequencer #(.MM_WAIT(MM_WAIT3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(i3_valid), .in_ready(i3_ready), .in_data(i3_data),
    .layer(layer3), .l1val(l1val3), .l2val(l2val3), .x_in(x3_in), .mat_out(mat3),
    .out_valid(o3_valid), .out_ready(o3_ready), .out_data(o3_data), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stub: l1 weights all 1.0, l2 identity, l3 all 1.0, zero biases, Q8.8 products.
  always_comb begin
    int acc;
    acc = 0;
    for (int j = 0; j < N; j++) acc += (int'($signed(l2val[j])) * 256) >>> 8;
    for (int i = 0; i < N; i++) begin
      case (layer)
        3'd0:    mat_out[i] = 16'((int'($signed(x_in)) * 256) >>> 8);
        3'd1:    mat_out[i] = 16'((int'($signed(l1val[i])) * 256) >>> 8);
        3'd2:    mat_out[i] = 16'(acc);
        default: mat_out[i] = '0;
      endcase
    end
  end

  always_comb begin
    int acc;
    acc = 0;
    for (int j = 0; j < N; j++) acc += (int'($signed(l2val3[j])) * 256) >>> 8;
    for (int i = 0; i < N; i++) begin
      case (layer3)
        3'd0:    mat3[i] = 16'((int'($signed(x3_in)) * 256) >>> 8);
        3'd1:    mat3[i] = 16'((int'($signed(l1val3[i])) * 256) >>> 8);
        3'd2:    mat3[i] = 16'(acc);
        default: mat3[i] = '0;
      endcase
    end
  end

  function automatic word_t act_ref(input word_t x);
`ifdef NN_SEQ_RELU_EN
    return ($signed(x) < 0) ? 16'h0000 : x;
`else
    return x;
`endif
  endfunction

  // Output = sum of 16 equal hidden words, each 1.0 * act(x).
  function automatic word_t infer_ref(input word_t x);
    return 16'(int'($signed(act_ref(x))) * N);
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input word_t d, input logic r, input int cycles);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    repeat (cycles) @(negedge clk);
  endtask

  // Submits x with out_ready low; returns with the result held, lat = cycles from accept to out_valid.
  task automatic doInference(input word_t x, output int lat);
    applyStimulus(1'b1, x, 1'b0, 1);
    lat = 1;
    while (!out_valid && lat < 50) begin
      applyStimulus(1'b0, 16'h0000, 1'b0, 1);
      lat++;
    end
  endtask

  // Reference model: tracks phase since accept and the pending result.
  logic  m_run, m_done;
  int    m_k;
  word_t m_exp, m_out, m_hid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_k    <= 0;
      m_exp  <= '0;
      m_out  <= '0;
      m_hid  <= '0;
    end else if (m_done) begin
      if (out_ready) m_done <= 1'b0;
    end else if (m_run) begin
      if (m_k == 3 * MM_WAIT - 1) begin
        m_run  <= 1'b0;
        m_done <= 1'b1;
        m_out  <= m_exp;
      end else begin
        m_k <= m_k + 1;
      end
    end else if (in_valid) begin
      m_run <= 1'b1;
      m_k   <= 0;
      m_exp <= infer_ref(in_data);
      m_hid <= act_ref(in_data);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("model_layer", layer, m_run ? 3'(m_k / MM_WAIT) : 3'd7);
      checkOutput("model_in_ready", in_ready, !(m_run || m_done));
      checkOutput("model_busy", busy, m_run || m_done);
      checkOutput("model_out_valid", out_valid, m_done);
      checkOutput("model_out_data", out_data, m_out);
      if (m_done) begin
        for (int i = 0; i < N; i++) begin
          checkOutput("model_l1val", l1val[i], m_hid);
          checkOutput("model_l2val", l2val[i], m_hid);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int first_valid;
    int nres;
    word_t res [2];
    logic [2:0] trace [27];

    in_valid = 0; in_data = '0; out_ready = 0;
    i3_valid = 0; i3_data = '0; o3_ready = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_layer", layer, 3'd7);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_data", out_data, 16'h0000);
    checkOutput("rst_x_in", x_in, 16'h0000);
    checkOutput("rst_busy", busy, 1'b0);
    rst_n = 1;
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1'b1);

    $display("[TB] sample 0x0100, consumer always ready");
    applyStimulus(1'b1, 16'h0100, 1'b1, 1);
    checkOutput("t1_layer0", layer, 3'd0);
    checkOutput("t1_x_in", x_in, 16'h0100);
    checkOutput("t1_in_ready", in_ready, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1);
    checkOutput("t1_layer1", layer, 3'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1);
    checkOutput("t1_layer2", layer, 3'd2);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1);
    checkOutput("t1_out_valid", out_valid, 1'b1);
    checkOutput("t1_out_data", out_data, 16'h1000);
    checkOutput("t1_l2val", l2val[15], 16'h0100);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1);
    checkOutput("t1_out_valid_drop", out_valid, 1'b0);
    checkOutput("t1_in_ready_back", in_ready, 1'b1);

    $display("[TB] negative sample 0xFF00");
    doInference(16'hFF00, lat);
    checkOutput("t2_latency", 16'(lat), 16'(3 * MM_WAIT + 1));
`ifdef NN_SEQ_RELU_EN
    checkOutput("t2_out_data", out_data, 16'h0000);
    checkOutput("t2_l1val", l1val[3], 16'h0000);
`else
    checkOutput("t2_out_data", out_data, 16'hF000);
    checkOutput("t2_l1val", l1val[3], 16'hFF00);
`endif
    applyStimulus(1'b0, 16'h0000, 1'b1, 1);
    checkOutput("t2_out_valid_drop", out_valid, 1'b0);

    $display("[TB] backpressure with ignored input pulses");
    doInference(16'h0080, lat);
    checkOutput("t3_out_data", out_data, 16'h0800);
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i % 2) == 0, 16'h0300, 1'b0, 1);
      checkOutput("t3_hold_valid", out_valid, 1'b1);
      checkOutput("t3_hold_data", out_data, 16'h0800);
      checkOutput("t3_hold_in_ready", in_ready, 1'b0);
    end
    applyStimulus(1'b0, 16'h0000, 1'b1, 1);
    checkOutput("t3_release_valid", out_valid, 1'b0);
    checkOutput("t3_release_busy", busy, 1'b0);
    checkOutput("t3_release_in_ready", in_ready, 1'b1);

    $display("[TB] reset during layer 1");
    applyStimulus(1'b1, 16'h0300, 1'b0, 1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1);
    checkOutput("t4_in_l1", layer, 3'd1);
    #2 rst_n = 0;
    #1;
    checkOutput("t4_async_layer", layer, 3'd7);
    checkOutput("t4_async_valid", out_valid, 1'b0);
    checkOutput("t4_async_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checkOutput("t4_in_ready", in_ready, 1'b1);
    checkOutput("t4_l1val_cleared", l1val[0], 16'h0000);
    doInference(16'h0200, lat);
    checkOutput("t4_out_data", out_data, 16'h2000);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1);

    $display("[TB] MM_WAIT=3 back-to-back samples");
    first_valid = 0;
    nres = 0;
    i3_valid = 1; i3_data = 16'h0100; o3_ready = 1;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      trace[c] = layer3;
      if (c == 1) i3_data = 16'h0080;
      if (c == 12) i3_valid = 0;
      if (o3_valid) begin
        if (nres < 2) res[nres] = o3_data;
        nres++;
        if (first_valid == 0) first_valid = c;
      end
    end
    for (int c = 1; c <= 9; c++) checkOutput("t5_layer_hold", trace[c], 3'((c - 1) / 3));
    checkOutput("t5_layer_idle", trace[10], 3'd7);
    checkOutput("t5_latency", 16'(first_valid), 16'd10);
    checkOutput("t5_result_count", 16'(nres), 16'd2);
    checkOutput("t5_result0", res[0], 16'h1000);
    checkOutput("t5_result1", res[1], 16'h0800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
